// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: operands, opcode and start in,
// registered results, flags and the busy/done handshake out.
interface alu_multicycle_if #(
   parameter int WIDTH = 16
);
   logic signed [WIDTH-1:0] in1;
   logic signed [WIDTH-1:0] in2;
   logic        [3:0]       ctrl;
   logic                    start;
   logic signed [WIDTH-1:0] out;
   logic signed [WIDTH-1:0] r0;
   logic                    overflow_flag;
   logic                    div_by_zero;
   logic                    busy;
   logic                    done;

   modport master (
      output in1, in2, ctrl, start,
      input  out, r0, overflow_flag, div_by_zero, busy, done
   );

   modport slave (
      input  in1, in2, ctrl, start,
      output out, r0, overflow_flag, div_by_zero, busy, done
   );
endinterface

// File: rtl/alu_multicycle.sv
// Sequential signed ALU: single-cycle add/sub/and/or, iterative shift-add multiply
// and restoring divide on magnitudes, with registered results and busy/done handshake.
//
// state    | meaning
// S_IDLE   | waiting for start; operands and opcode latched on accept
// S_EXEC   | one mul/div iteration per cycle, counter counts WIDTH..1
// S_FINISH | sign fix-up, result/flag registers written, done pulsed
module alu_multicycle #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   alu_multicycle_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h4;
   localparam logic [3:0] OP_DIV  = 4'h8;
   localparam logic [3:0] OP_AND  = 4'hC;
   localparam logic [3:0] OP_OR   = 4'hE;
   localparam logic [3:0] OP_ADD2 = 4'hF;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FINISH} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_mag;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;
   logic             r_dovf;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_r0;
   logic             r_ovf;
   logic             r_dbz;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0]   w_in1_mag;
   logic [WIDTH-1:0]   w_in2_mag;
   logic               w_in2_zero;
   logic               w_div_ovf;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_sub;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0]   w_sum;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_fin_out;
   logic [WIDTH-1:0]   w_fin_r0;
   logic               w_fin_ovf;
   logic               w_fin_dbz;

   // The most-negative input maps to itself, which reads correctly as unsigned.
   assign w_in1_mag  = bus.in1[WIDTH-1] ? -bus.in1 : bus.in1;
   assign w_in2_mag  = bus.in2[WIDTH-1] ? -bus.in2 : bus.in2;
   assign w_in2_zero = (bus.in2 == '0);
   assign w_div_ovf  = (bus.in1 == MIN_NEG) && (bus.in2 == '1);

   assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : '0);
   assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_mag});
   assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_mag;

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;
   assign w_sum    = r_a + r_b;
   assign w_diff   = r_a - r_b;

   always_comb begin
      w_fin_out = r_out;
      w_fin_r0  = r_r0;
      w_fin_ovf = 1'b0;
      w_fin_dbz = 1'b0;
      case (r_op)
         OP_ADD, OP_ADD2: begin
            w_fin_out = w_sum;
            w_fin_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_fin_out = w_diff;
            w_fin_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_MUL: begin
            w_fin_out = w_prod_s[WIDTH-1:0];
            w_fin_r0  = w_prod_s[2*WIDTH-1:WIDTH];
            w_fin_ovf = (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});
         end
         OP_DIV: begin
            if (r_dz) begin
               w_fin_out = '1;
               w_fin_r0  = r_a;
               w_fin_ovf = 1'b1;
               w_fin_dbz = 1'b1;
            end else if (r_dovf) begin
               w_fin_out = MIN_NEG;
               w_fin_r0  = '0;
               w_fin_ovf = 1'b1;
            end else begin
               w_fin_out = r_neg_q ? -r_lo : r_lo;
               w_fin_r0  = r_neg_r ? -r_hi : r_hi;
            end
         end
         OP_AND:  w_fin_out = r_a & r_b;
         OP_OR:   w_fin_out = r_a | r_b;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_mag   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_dovf  <= 1'b0;
         r_out   <= '0;
         r_r0    <= '0;
         r_ovf   <= 1'b0;
         r_dbz   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_op    <= bus.ctrl;
                  r_a     <= bus.in1;
                  r_b     <= bus.in2;
                  r_neg_q <= bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
                  r_neg_r <= bus.in1[WIDTH-1];
                  r_dz    <= w_in2_zero;
                  r_dovf  <= w_div_ovf;
                  r_busy  <= 1'b1;
                  r_hi    <= '0;
                  if (bus.ctrl == OP_MUL) begin
                     r_mag   <= w_in1_mag;
                     r_lo    <= w_in2_mag;
                     r_cnt   <= CW'(WIDTH);
                     r_state <= S_EXEC;
                  end else if (bus.ctrl == OP_DIV && !w_in2_zero && !w_div_ovf) begin
                     r_mag   <= w_in2_mag;
                     r_lo    <= w_in1_mag;
                     r_cnt   <= CW'(WIDTH);
                     r_state <= S_EXEC;
                  end else begin
                     r_state <= S_FINISH;
                  end
               end
            end
            S_EXEC: begin
               if (r_op == OP_MUL) begin
                  r_hi <= w_mul_sum[WIDTH:1];
                  r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
               end else if (w_div_ge) begin
                  r_hi <= w_div_sub;
                  r_lo <= {r_lo[WIDTH-2:0], 1'b1};
               end else begin
                  r_hi <= w_div_shift[WIDTH-1:0];
                  r_lo <= {r_lo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) r_state <= S_FINISH;
            end
            S_FINISH: begin
               r_out   <= w_fin_out;
               r_r0    <= w_fin_r0;
               r_ovf   <= w_fin_ovf;
               r_dbz   <= w_fin_dbz;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.out           = r_out;
   assign bus.r0            = r_r0;
   assign bus.overflow_flag = r_ovf;
   assign bus.div_by_zero   = r_dbz;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=16): one task per feature, hand-computed
// expectations, latency counted in rising edges after the accepting edge.
module tb_alu_multicycle;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   alu_multicycle_if #(.WIDTH(16)) bus ();

   alu_multicycle #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one op and returns edges from accept to done (-1 if it never came).
   task automatic run_op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
      @(negedge clk);
      bus.ctrl  = c;
      bus.in1   = a;
      bus.in2   = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.in1   = 16'hDEAD;
      bus.in2   = 16'hBEEF;
      bus.ctrl  = 4'h3;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.ctrl = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.out !== 16'h0000) begin n_err++; $display("FAIL reset_out got %h want 0000", bus.out); end
      n_cmp++; if (bus.r0 !== 16'h0000) begin n_err++; $display("FAIL reset_r0 got %h want 0000", bus.r0); end
      n_cmp++; if ({bus.overflow_flag, bus.div_by_zero, bus.busy, bus.done} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags got %b want 0000", {bus.overflow_flag, bus.div_by_zero, bus.busy, bus.done});
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mul();
      int lat;
      run_op(4'h4, 16'hFED4, 16'h00C8, lat);   // -300 * 200 = -60000
      n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL mul1_latency got %0d want 17", lat); end
      n_cmp++; if (bus.out !== 16'h15A0) begin n_err++; $display("FAIL mul1_out got %h want 15a0", bus.out); end
      n_cmp++; if (bus.r0 !== 16'hFFFF) begin n_err++; $display("FAIL mul1_r0 got %h want ffff", bus.r0); end
      n_cmp++; if ({bus.overflow_flag, bus.div_by_zero} !== 2'b10) begin
         n_err++; $display("FAIL mul1_flags got %b want 10", {bus.overflow_flag, bus.div_by_zero});
      end
      run_op(4'h4, 16'h0003, 16'hFFFC, lat);   // 3 * -4
      n_cmp++; if (bus.out !== 16'hFFF4) begin n_err++; $display("FAIL mul2_out got %h want fff4", bus.out); end
      n_cmp++; if (bus.r0 !== 16'hFFFF) begin n_err++; $display("FAIL mul2_r0 got %h want ffff", bus.r0); end
      n_cmp++; if (bus.overflow_flag !== 1'b0) begin n_err++; $display("FAIL mul2_ovf got %b want 0", bus.overflow_flag); end
   endtask

   task automatic test_addsub();
      int lat;
      run_op(4'h1, 16'h7FFF, 16'h0001, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency got %0d want 1", lat); end
      n_cmp++; if (bus.out !== 16'h8000) begin n_err++; $display("FAIL add_out got %h want 8000", bus.out); end
      n_cmp++; if (bus.overflow_flag !== 1'b1) begin n_err++; $display("FAIL add_ovf got %b want 1", bus.overflow_flag); end
      n_cmp++; if (bus.r0 !== 16'hFFFF) begin n_err++; $display("FAIL add_r0_held got %h want ffff", bus.r0); end
      run_op(4'h2, 16'h8000, 16'h0001, lat);
      n_cmp++; if ({bus.out, bus.overflow_flag} !== {16'h7FFF, 1'b1}) begin
         n_err++; $display("FAIL sub_ovf got %h/%b want 7fff/1", bus.out, bus.overflow_flag);
      end
      run_op(4'hF, 16'h0005, 16'hFFFE, lat);
      n_cmp++; if ({bus.out, bus.overflow_flag} !== {16'h0003, 1'b0}) begin
         n_err++; $display("FAIL addF got %h/%b want 0003/0", bus.out, bus.overflow_flag);
      end
   endtask

   task automatic test_div();
      int lat;
      run_op(4'h8, 16'hFFF9, 16'h0002, lat);   // -7 / 2
      n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL div1_latency got %0d want 17", lat); end
      n_cmp++; if ({bus.out, bus.r0} !== {16'hFFFD, 16'hFFFF}) begin
         n_err++; $display("FAIL div1_result got %h/%h want fffd/ffff", bus.out, bus.r0);
      end
      n_cmp++; if ({bus.overflow_flag, bus.div_by_zero} !== 2'b00) begin
         n_err++; $display("FAIL div1_flags got %b want 00", {bus.overflow_flag, bus.div_by_zero});
      end
      run_op(4'h8, 16'h0064, 16'hFFF9, lat);   // 100 / -7 = -14 r 2
      n_cmp++; if ({bus.out, bus.r0} !== {16'hFFF2, 16'h0002}) begin
         n_err++; $display("FAIL div2_result got %h/%h want fff2/0002", bus.out, bus.r0);
      end
      run_op(4'h8, 16'h8000, 16'hFFFF, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL divovf_latency got %0d want 1", lat); end
      n_cmp++; if ({bus.out, bus.r0} !== {16'h8000, 16'h0000}) begin
         n_err++; $display("FAIL divovf_result got %h/%h want 8000/0000", bus.out, bus.r0);
      end
      n_cmp++; if ({bus.overflow_flag, bus.div_by_zero} !== 2'b10) begin
         n_err++; $display("FAIL divovf_flags got %b want 10", {bus.overflow_flag, bus.div_by_zero});
      end
   endtask

   task automatic test_div_zero();
      int lat;
      run_op(4'h8, 16'h0005, 16'h0000, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dz_latency got %0d want 1", lat); end
      n_cmp++; if ({bus.out, bus.r0} !== {16'hFFFF, 16'h0005}) begin
         n_err++; $display("FAIL dz_result got %h/%h want ffff/0005", bus.out, bus.r0);
      end
      n_cmp++; if ({bus.overflow_flag, bus.div_by_zero} !== 2'b11) begin
         n_err++; $display("FAIL dz_flags got %b want 11", {bus.overflow_flag, bus.div_by_zero});
      end
      run_op(4'h3, 16'h0001, 16'h0002, lat);   // no-op
      n_cmp++; if ({bus.out, bus.r0, bus.overflow_flag, bus.div_by_zero} !== {16'hFFFF, 16'h0005, 2'b00}) begin
         n_err++; $display("FAIL noop got %h/%h/%b%b want ffff/0005/00", bus.out, bus.r0, bus.overflow_flag, bus.div_by_zero);
      end
      run_op(4'hC, 16'h00F0, 16'h0FF0, lat);
      n_cmp++; if ({bus.out, bus.overflow_flag, bus.div_by_zero} !== {16'h00F0, 2'b00}) begin
         n_err++; $display("FAIL and got %h/%b%b want 00f0/00", bus.out, bus.overflow_flag, bus.div_by_zero);
      end
   endtask

   task automatic test_handshake();
      int first;
      int pulses;
      @(negedge clk);
      bus.ctrl = 4'h4; bus.in1 = 16'h0064; bus.in2 = 16'hFFFB; bus.start = 1'b1;   // 100 * -5
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_cmp++; if ({bus.busy, bus.done} !== 2'b10) begin n_err++; $display("FAIL hs_busy_after_k got %b want 10", {bus.busy, bus.done}); end
      first = -1;
      pulses = 0;
      for (int e = 1; e <= 25; e++) begin
         @(negedge clk);
         if (e == 5) begin
            bus.ctrl = 4'h8; bus.in1 = 16'h0009; bus.in2 = 16'h0003; bus.start = 1'b1;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (e == 16) begin
            n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL hs_busy_k16 got %b want 1", bus.busy); end
         end
         if (bus.done) begin
            pulses++;
            if (first < 0) first = e;
         end
      end
      n_cmp++; if (first !== 17) begin n_err++; $display("FAIL hs_done_edge got %0d want 17", first); end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL hs_done_pulses got %0d want 1", pulses); end
      n_cmp++; if ({bus.out, bus.r0, bus.overflow_flag} !== {16'hFE0C, 16'hFFFF, 1'b0}) begin
         n_err++; $display("FAIL hs_mul_result got %h/%h/%b want fe0c/ffff/0", bus.out, bus.r0, bus.overflow_flag);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(4'h4, 16'h0003, 16'hFFFC, lat);
      n_cmp++; if ({bus.done, bus.busy} !== 2'b10) begin n_err++; $display("FAIL b2b_done_cycle got %b want 10", {bus.done, bus.busy}); end
      bus.ctrl = 4'hE; bus.in1 = 16'h0F00; bus.in2 = 16'h00F0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_cmp++; if ({bus.done, bus.busy} !== 2'b01) begin n_err++; $display("FAIL b2b_accept got %b want 01", {bus.done, bus.busy}); end
      @(posedge clk); #1;
      n_cmp++; if ({bus.done, bus.busy, bus.out} !== {2'b10, 16'h0FF0}) begin
         n_err++; $display("FAIL b2b_or got %b%b/%h want 10/0ff0", bus.done, bus.busy, bus.out);
      end
   endtask

   task automatic test_reset_midop();
      int lat;
      int pulses;
      @(negedge clk);
      bus.ctrl = 4'h8; bus.in1 = 16'h0064; bus.in2 = 16'h0007; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if ({bus.out, bus.r0} !== 32'h0) begin n_err++; $display("FAIL rst_mid_result got %h/%h want 0000/0000", bus.out, bus.r0); end
      n_cmp++; if ({bus.overflow_flag, bus.div_by_zero, bus.busy, bus.done} !== 4'b0000) begin
         n_err++; $display("FAIL rst_mid_flags got %b want 0000", {bus.overflow_flag, bus.div_by_zero, bus.busy, bus.done});
      end
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", pulses); end
      run_op(4'h1, 16'h0002, 16'h0003, lat);
      n_cmp++; if ({lat, bus.out} !== {32'd1, 16'h0005}) begin
         n_err++; $display("FAIL rst_mid_next_op got %0d/%h want 1/0005", lat, bus.out);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_mul();
      test_addsub();
      test_div();
      test_div_zero();
      test_handshake();
      test_back_to_back();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, sequential successor to the datapath ALU. It executes the same 4-bit `ctrl` operation set on signed `WIDTH`-bit operands. Multiply uses an iterative shift-add and divide uses an iterative restoring sequence, both under a start/busy/done handshake. Results and flags are registered and held between operations, so the pipeline control can stall on `busy` instead of paying a combinational multiplier or divider in the execute stage.

## Interface
- `WIDTH`, default 16: operand and result width. Legal values are >= 4.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `in1`, `in2`  in  WIDTH: signed operands, sampled only on an accepted `start`.
- `ctrl`  in  4: operation code, sampled with the operands.
- `start`  in  1: request. It is accepted only when `busy`=0.
- `out`  out  WIDTH: signed result (quotient, or low product half).
- `r0`  out  WIDTH: signed remainder, or high product half.
- `overflow_flag`  out  1: signed overflow of the last operation.
- `div_by_zero`  out  1: the last operation was a divide with `in2`=0.
- `busy`  out  1: an operation is in progress.
- `done`  out  1: one-cycle completion pulse.

## Operation
- Opcodes:
  - 1 = add, 2 = sub (`in1`-`in2`), 4 = mul, 8 = div.
  - C = AND, E = OR, F = add.
  - Any other code is a no-op: it completes, leaves `out`/`r0` unchanged, clears both flags and pulses `done`.
- FSM states: IDLE, EXEC, FINISH.
  - IDLE + `start`, with a single-cycle op, div-by-zero, or div overflow: go to FINISH.
  - IDLE + `start`, with mul or another div: go to EXEC with a counter loaded to WIDTH.
  - EXEC runs one iteration per cycle, decrements the counter, and goes to FINISH when the counter reaches 1.
  - FINISH writes the result registers, asserts `done` and returns to IDLE.
- Add/sub: `overflow_flag` = signed overflow, i.e. the operand signs agree (add) or differ (sub) and the result sign differs from `in1`.
- AND/OR: `overflow_flag`=0.
- Only mul and div write `r0`. All other ops leave `r0` unchanged.
- Mul:
  - Operate on magnitudes of the latched operands and apply the sign in FINISH.
  - `{r0,out}` = full 2·WIDTH signed product.
  - `overflow_flag`=1 when `r0` is not the sign extension of `out[WIDTH-1]`.
- Div:
  - Quotient truncates toward zero, and the remainder takes the dividend's sign, so `in1` = q·`in2` + r.
  - Operate on magnitudes and fix up signs in FINISH.
  - The magnitude of the most-negative value is handled as an unsigned WIDTH-bit value.
- Divide by zero: `out`=all ones, `r0`=`in1`, `div_by_zero`=1, `overflow_flag`=1.
- Most-negative / -1: `out`=most-negative, `r0`=0, `overflow_flag`=1, `div_by_zero`=0.
- Every completion rewrites `overflow_flag` and `div_by_zero`.
- `start` while `busy`=1 is ignored: no latch and no effect on the op in flight.
- `in1`/`in2`/`ctrl` may change freely after acceptance, because internal copies are used.

## Timing
- Reset values: `out`=0, `r0`=0, `overflow_flag`=0, `div_by_zero`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Reset mid-operation aborts the op. No `done` is produced, and outputs return to their reset values on the reset edge.
- Let edge k be the rising edge at which `start` is accepted.
- Single-cycle ops, div-by-zero and div overflow:
  - Results and `done`=1 become valid after edge k+1.
  - `busy`=1 after edge k, and `busy`=0 after edge k+1.
- Mul/div:
  - Results and `done` become valid after edge k+WIDTH+1 (17 edges for WIDTH=16).
  - `busy`=1 from edge k through edge k+WIDTH.
- `done` is high for exactly one cycle, concurrent with `busy`=0. A `start` in that same cycle is accepted, so back-to-back ops have no bubble.
- Outputs change only on a FINISH edge or a reset edge, and hold otherwise.

## Test plan
- Add overflow: add 0x7FFF + 0x0001 → `out`=0x8000, `overflow_flag`=1, `done` after edge k+1, `r0` unchanged.
- Signed mul: mul -300 × 200 → `out`=0x15A0, `r0`=0xFFFF, `overflow_flag`=1, `done` exactly after edge k+17. Then mul 3 × -4 → `out`=0xFFF4, `r0`=0xFFFF, `overflow_flag`=0.
- Signed div: div -7 / 2 → `out`=0xFFFD, `r0`=0xFFFF, `overflow_flag`=0, after edge k+17. Then div 0x8000 / 0xFFFF → `out`=0x8000, `r0`=0, `overflow_flag`=1, after edge k+1.
- Div by zero: div 5 / 0 → `out`=0xFFFF, `r0`=0x0005, `div_by_zero`=1, `overflow_flag`=1, `done` after edge k+1. A following AND 0x00F0 & 0x0FF0 → `out`=0x00F0, both flags 0.
- Handshake:
  - Start a mul, then pulse `start` with a div at cycle 5 → ignored. The mul result is intact and only one `done` pulse occurs.
  - Issue an OR in the `done` cycle → accepted, `done` pulses again one edge later.
- Reset mid-op: assert `reset` at cycle 8 of a div → all outputs 0, `busy`=0, no `done` pulse. The next op completes normally.
